// File: rtl/matmul_output_accumulator.sv
// matmul_output_accumulator: gathers staggered main/proxy column results into a ROWS x COLS matrix and drains it row-major.
// Define OUTACC_SAT_EN to make every accumulate saturate to signed WORD_SIZE limits instead of wrapping.
module matmul_output_accumulator #(
    parameter int WORD_SIZE   = 16,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int PROXY_HOLD  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [COLS*WORD_SIZE-1:0]   main_data,
    input  logic [COLS-1:0]             main_valid,
    input  logic [COLS*WORD_SIZE-1:0]   proxy_data,
    input  logic [COLS-1:0]             proxy_valid,
    output logic [COLS-1:0]             cols_done,
    output logic [COLS-1:0]             overflow,
    output logic                        busy,
    output logic [WORD_SIZE-1:0]        rd_data,
    output logic [$clog2(ROWS)-1:0]     rd_row,
    output logic [$clog2(COLS)-1:0]     rd_col,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic                        rd_last
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int NW = $clog2(ROWS + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int PW = $clog2(PROXY_HOLD + 1);
`ifdef OUTACC_SAT_EN
    localparam int SW = WORD_SIZE + 2;
    localparam logic signed [SW-1:0] SMAX = {3'b000, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {3'b111, {(WORD_SIZE-1){1'b0}}};
`endif

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    state_t               state, state_next;
    logic [WORD_SIZE-1:0] matrix   [ROWS][COLS];
    logic [WORD_SIZE-1:0] next_val [ROWS][COLS];
    logic [NW-1:0]        m_row [COLS];
    logic [NW-1:0]        p_row [COLS];
    logic [HW-1:0]        m_ph  [COLS];
    logic [PW-1:0]        p_ph  [COLS];
    logic [COLS-1:0]      m_acc, p_acc;
    logic [RW-1:0]        dr_row;
    logic [CW-1:0]        dr_col;

    // Same-row main+proxy is folded as one 3-operand sum so saturation happens once.
    function automatic logic [WORD_SIZE-1:0] fold(input logic [WORD_SIZE-1:0] a, b, d);
`ifdef OUTACC_SAT_EN
        logic signed [SW-1:0] s;
        s = $signed({{2{a[WORD_SIZE-1]}}, a}) + $signed({{2{b[WORD_SIZE-1]}}, b})
          + $signed({{2{d[WORD_SIZE-1]}}, d});
        return s > SMAX ? SMAX[WORD_SIZE-1:0] : s < SMIN ? SMIN[WORD_SIZE-1:0] : s[WORD_SIZE-1:0];
`else
        return a + b + d;
`endif
    endfunction

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            m_acc[c]     = state == ACCUM && main_valid[c] && m_ph[c] == '0;
            p_acc[c]     = state == ACCUM && proxy_valid[c] && p_ph[c] == '0;
            cols_done[c] = m_row[c] == NW'(ROWS);
        end
    end

    // Full counters never match a real row, so overflowing samples add nothing.
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                next_val[r][c] = fold(matrix[r][c],
                    m_acc[c] && m_row[c] == NW'(r) ? main_data[c*WORD_SIZE +: WORD_SIZE] : '0,
                    p_acc[c] && p_row[c] == NW'(r) ? proxy_data[c*WORD_SIZE +: WORD_SIZE] : '0);
    end

    always_comb begin
        busy       = state != DONE;
        rd_valid   = state == DRAIN;
        rd_last    = rd_valid && dr_row == RW'(ROWS - 1) && dr_col == CW'(COLS - 1);
        rd_data    = rd_valid ? matrix[dr_row][dr_col] : '0;
        rd_row     = rd_valid ? dr_row : '0;
        rd_col     = rd_valid ? dr_col : '0;
        state_next = state;
        if (state == ACCUM && &cols_done)
            state_next = DRAIN;
        else if (rd_last && rd_ready)
            state_next = DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state    <= ACCUM;
            dr_row   <= '0;
            dr_col   <= '0;
            overflow <= '0;
            for (int c = 0; c < COLS; c++) begin
                m_row[c] <= '0;
                p_row[c] <= '0;
                m_ph[c]  <= '0;
                p_ph[c]  <= '0;
                for (int r = 0; r < ROWS; r++)
                    matrix[r][c] <= '0;
            end
        end else begin
            state <= state_next;
            for (int c = 0; c < COLS; c++) begin
                m_ph[c] <= (!main_valid[c] || m_ph[c] == HW'(HOLD_CYCLES - 1)) ? '0 : m_ph[c] + 1'b1;
                p_ph[c] <= (!proxy_valid[c] || p_ph[c] == PW'(PROXY_HOLD - 1)) ? '0 : p_ph[c] + 1'b1;
                if (m_acc[c] && !cols_done[c])
                    m_row[c] <= m_row[c] + 1'b1;
                if (p_acc[c] && p_row[c] != NW'(ROWS))
                    p_row[c] <= p_row[c] + 1'b1;
                if ((m_acc[c] && cols_done[c]) || (p_acc[c] && p_row[c] == NW'(ROWS)))
                    overflow[c] <= 1'b1;
                for (int r = 0; r < ROWS; r++)
                    matrix[r][c] <= next_val[r][c];
            end
            if (state == ACCUM) begin
                dr_row <= '0;
                dr_col <= '0;
            end else if (rd_valid && rd_ready) begin
                dr_col <= dr_col == CW'(COLS - 1) ? '0 : dr_col + 1'b1;
                if (dr_col == CW'(COLS - 1))
                    dr_row <= dr_row + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_matmul_output_accumulator.sv
// tb_matmul_output_accumulator: directed scenarios plus random traffic, checked every cycle against a behavioural matrix model.
module tb_matmul_output_accumulator;
    localparam int W = 16, R = 4, C = 4, H = 2, P = 2;

    logic           clk = 0, rst, clear, rd_ready;
    logic [C*W-1:0] md, pd;
    logic [C-1:0]   mv, pv, cols_done, overflow;
    logic           busy, rd_valid, rd_last;
    logic [W-1:0]   rd_data;
    logic [1:0]     rd_row, rd_col;

    matmul_output_accumulator #(.WORD_SIZE(W), .ROWS(R), .COLS(C), .HOLD_CYCLES(H), .PROXY_HOLD(P)) dut (
        .clk(clk), .rst(rst), .clear(clear), .main_data(md), .main_valid(mv),
        .proxy_data(pd), .proxy_valid(pv), .cols_done(cols_done), .overflow(overflow),
        .busy(busy), .rd_data(rd_data), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, got[R*C];
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: matrix of signed words, per-column fill counts and run lengths of the valid inputs.
    shortint mm[R][C];
    int mrow[C], prow[C], runm[C], runp[C], addv[R], mode = 0, k = 0;
    bit ovf[C], all_done;

    function automatic int clampw(input int s);
`ifdef OUTACC_SAT_EN
        return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
`else
        return s;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst || clear) begin
            mode = 0; k = 0;
            for (int c = 0; c < C; c++) begin
                mrow[c] = 0; prow[c] = 0; runm[c] = 0; runp[c] = 0; ovf[c] = 0;
                for (int r = 0; r < R; r++) mm[r][c] = 0;
            end
        end else begin
            if (mode == 0) begin
                all_done = 1;
                for (int c = 0; c < C; c++) all_done &= (mrow[c] == R);
                for (int c = 0; c < C; c++) begin
                    for (int r = 0; r < R; r++) addv[r] = 0;
                    if (mv[c] && runm[c] % H == 0) begin
                        if (mrow[c] < R) begin addv[mrow[c]] += int'(shortint'(md[c*W +: W])); mrow[c]++; end
                        else ovf[c] = 1;
                    end
                    if (pv[c] && runp[c] % P == 0) begin
                        if (prow[c] < R) begin addv[prow[c]] += int'(shortint'(pd[c*W +: W])); prow[c]++; end
                        else ovf[c] = 1;
                    end
                    for (int r = 0; r < R; r++) mm[r][c] = shortint'(clampw(int'(mm[r][c]) + addv[r]));
                end
                if (all_done) begin mode = 1; k = 0; end
            end else if (mode == 1 && rd_ready) begin
                if (k == R*C-1) mode = 2;
                k++;
            end
            for (int c = 0; c < C; c++) begin
                runm[c] = mv[c] ? runm[c] + 1 : 0;
                runp[c] = pv[c] ? runp[c] + 1 : 0;
            end
        end
    end

    logic [C-1:0] e_cd, e_ov;
    logic [W-1:0] e_d;
    always @(negedge clk) if (chk_en) begin
        for (int c = 0; c < C; c++) begin e_cd[c] = mrow[c] == R; e_ov[c] = ovf[c]; end
        e_d = mode == 1 ? mm[(k % (R*C)) / C][k % C] : '0;
        check("busy", busy, mode != 2);
        check("rd_valid", rd_valid, mode == 1);
        check("rd_last", rd_last, mode == 1 && k == R*C-1);
        check("rd_row", rd_row, mode == 1 ? (k / C) : 0);
        check("rd_col", rd_col, mode == 1 ? (k % C) : 0);
        check("rd_data", rd_data, e_d);
        check("cols_done", cols_done, e_cd);
        check("overflow", overflow, e_ov);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1; tick(); clear = 0;
    endtask

    task automatic stagger();
        for (int t = 0; t < C + 2*R - 1; t++) begin
            for (int c = 0; c < C; c++) begin
                mv[c] = t >= c && t - c < 2*R;
                md[c*W +: W] = W'(10*((t - c)/2) + c);
            end
            tick();
        end
        mv = '0;
    endtask

    task automatic fill();
        int g = 0;
        mv = '1; md = '0; pv = '0;
        while (!rd_valid && g < 40) begin tick(); g++; end
        mv = '0;
        check("fill_reaches_drain", rd_valid, 1);
    endtask

    task automatic drain(input int stall_at);
        int n = 0, st = 0, g = 0;
        rd_ready = 1;
        while (n < R*C && g < 100) begin
            @(negedge clk); g++;
            if (rd_valid) begin
                if (n == stall_at && st < 3) begin
                    rd_ready = 0; st++;
                    check("stall_row", rd_row, stall_at / C);
                    check("stall_col", rd_col, stall_at % C);
                end else begin
                    rd_ready = 1; got[n] = rd_data; n++;
                end
            end
        end
        check("drain_beats", n, R*C);
        tick(); rd_ready = 0; tick();
        check("done_busy", busy, 0);
    endtask

    initial begin
        rst = 0; clear = 0; mv = 0; pv = 0; md = 0; pd = 0; rd_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1; chk_en = 1;
        check("reset_busy", busy, 1);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_cols_done", cols_done, 0);

        stagger(); drain(-1);
        for (int i = 0; i < R*C; i++) check("stagger_entry", got[i], 10*(i/C) + i%C);

        pulse_clear();
        mv[1] = 1; md[W +: W] = 5; pv[1] = 1; pd[W +: W] = 3; tick();
        mv = 0; pv = 0; tick();
        fill(); drain(-1);
        check("same_row_sum", got[1], 8);

        pulse_clear();
        pv[1] = 1; pd[W +: W] = 0; tick(); pv = 0; tick();
        mv[1] = 1; md[W +: W] = 5; pv[1] = 1; pd[W +: W] = 3; tick();
        mv = 0; pv = 0; tick();
        fill(); drain(-1);
        check("diff_row_main", got[1], 5);
        check("diff_row_proxy", got[5], 3);

        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            mv[2] = 1; md[2*W +: W] = W'(i + 1); tick(); mv = 0; tick();
            if (i == 3) begin check("col2_done", cols_done[2], 1); check("col2_no_ovf", overflow[2], 0); end
            if (i == 4) check("col2_ovf", overflow[2], 1);
        end
        fill(); drain(-1);
        for (int r = 0; r < R; r++) check("col2_kept", got[r*C + 2], r + 1);

        pulse_clear();
        stagger(); drain(6);
        check("stall_entry", got[6], 12);

        pulse_clear();
        stagger(); rd_ready = 1; tick(); tick(); tick();
        clear = 1; tick(); clear = 0; rd_ready = 0;
        check("abort_rd_valid", rd_valid, 0);
        check("abort_busy", busy, 1);
        fill(); drain(-1);
        for (int i = 0; i < R*C; i++) check("abort_zero", got[i], 0);

        pulse_clear();
        mv = '1; md = {4{16'h0123}}; tick(); tick(); tick(); mv = 0;
        rst = 0; tick(); rst = 1;
        check("rst_cols_done", cols_done, 0);
        check("rst_busy", busy, 1);
        stagger(); drain(-1);
        check("rst_entry", got[5], 11);

        pulse_clear();
        mv[0] = 1; md[W-1:0] = 16'h7000; tick(); mv = 0; tick();
        pv[0] = 1; pd[W-1:0] = 16'h7000; tick(); pv = 0; tick();
        fill(); drain(-1);
`ifdef OUTACC_SAT_EN
        check("sat_entry", got[0], 32'h7FFF);
`else
        check("wrap_entry", got[0], 32'hE000);
`endif

        pulse_clear();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < C; c++) begin
                mv[c] = $urandom % 6 != 0;
                pv[c] = $urandom % 3 == 0;
            end
            md = {$urandom, $urandom};
            pd = {$urandom, $urandom};
            rd_ready = $urandom % 3 != 0;
            clear = !busy || $urandom % 120 == 0;
            rst = $urandom % 250 != 0;
            tick();
        end
        rst = 1; clear = 0; mv = 0; pv = 0; rd_ready = 0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
